// File: rtl/denise_palette_loader_pkg.sv
// Shared constants and types for the Denise palette loader.
//   COLOR00_ADDR / NOOP_ADDR : full 9-bit register addresses (bit 0 always 0)
//   PALETTE_SIZE, IDX_W, RGB_W: colour-table geometry
//   loader_state_t           : loader sequencer states
//   color_reg()              : register-bus address [8:1] of a colour entry
package denise_palette_loader_pkg;

   localparam logic [8:0]  COLOR00_ADDR = 9'h180;
   localparam logic [8:0]  NOOP_ADDR    = 9'h1FE;
   localparam int unsigned PALETTE_SIZE = 32;
   localparam int unsigned IDX_W        = 5;
   localparam int unsigned RGB_W        = 12;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StDone = 2'd2
   } loader_state_t;

   // base_word is already the [8:1] form of the COLOR00 address
   function automatic logic [7:0] color_reg(input logic [7:0]       base_word,
                                            input logic [IDX_W-1:0] idx);
      return base_word + {3'b000, idx};
   endfunction

endpackage

// File: rtl/denise_palette_shadow.sv
// Host-writable shadow copy of the 32-entry RGB444 palette.
//   clk_i   : pixel clock
//   we_i    : write strobe (already qualified with the clock enable)
//   waddr_i : entry written
//   wdata_i : RGB444 value written
//   raddr_i : entry read (asynchronous)
//   rdata_o : contents of entry raddr_i; a same-cycle write is not visible yet
// Contents are deliberately not reset so a palette survives a loader reset.
module denise_palette_shadow
   import denise_palette_loader_pkg::*;
(
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] waddr_i,
   input  logic [RGB_W-1:0] wdata_i,
   input  logic [IDX_W-1:0] raddr_i,
   output logic [RGB_W-1:0] rdata_o
);

   logic [RGB_W-1:0] mem_q [PALETTE_SIZE];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/denise_palette_loader.sv
// Bulk loader for the Denise colour registers COLOR00..COLOR31.
// Sits between the Agnus register bus and Denise; Agnus writes always pass
// through with one tick of latency, and queued palette entries are inserted
// only into idle bus slots while blanking.
//   clk, clk7_en, reset     : pixel clock, 7 MHz enable, sync active-high reset
//   bus_address_in/data_in  : register bus from Agnus
//   blank                   : insertion permitted only while high
//   wr_en/wr_index/wr_color : host shadow-palette write port
//   start                   : request a full palette load
//   reg_address_out/data_out: registered bus to Denise
//   busy, done              : load in progress / one-tick completion pulse
module denise_palette_loader
   import denise_palette_loader_pkg::*;
#(
   parameter logic [7:0]  IDLE_ADDR  = NOOP_ADDR[8:1],
   parameter logic [8:0]  COLOR0     = COLOR00_ADDR,
   parameter int unsigned NUM_COLORS = PALETTE_SIZE
) (
   input  logic             clk,
   input  logic             clk7_en,
   input  logic             reset,
   input  logic [8:1]       bus_address_in,
   input  logic [15:0]      bus_data_in,
   input  logic             blank,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [RGB_W-1:0] wr_color,
   input  logic             start,
   output logic [8:1]       reg_address_out,
   output logic [15:0]      data_out,
   output logic             busy,
   output logic             done
);

   localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_COLORS - 1);

   loader_state_t    state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             restart_q, restart_d;
   logic [7:0]       addr_q, addr_d;
   logic [15:0]      data_q, data_d;
   logic             done_q, done_d;

   logic [RGB_W-1:0] shadow_rdata;
   logic             insert;

   // Read happens before the write lands, so a same-tick write to idx_q
   // still issues the old colour.
   denise_palette_shadow u_shadow (
      .clk_i   (clk),
      .we_i    (wr_en & clk7_en),
      .waddr_i (wr_index),
      .wdata_i (wr_color),
      .raddr_i (idx_q),
      .rdata_o (shadow_rdata)
   );

   // Agnus traffic always wins; only genuinely idle slots are borrowed.
   assign insert = (state_q == StLoad) && blank && (bus_address_in == IDLE_ADDR);

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      restart_d = restart_q;
      addr_d    = bus_address_in;
      data_d    = bus_data_in;
      done_d    = 1'b0;

      if (insert) begin
         addr_d = color_reg(COLOR0[8:1], idx_q);
         data_d = {4'h0, shadow_rdata};
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               idx_d   = '0;
            end
         end
         StLoad: begin
            if (start) begin
               restart_d = 1'b1;
            end
            if (insert) begin
               // Terminal count is explicit so idx never wraps within a run
               if (idx_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         StDone: begin
            done_d    = 1'b1;
            restart_d = 1'b0;
            idx_d     = '0;
            // A start landing on the DONE tick is still a request made while busy
            if (restart_q || start) begin
               state_d = StLoad;
            end else begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         restart_q <= 1'b0;
         addr_q    <= IDLE_ADDR;
         data_q    <= '0;
         done_q    <= 1'b0;
      end else if (clk7_en) begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         restart_q <= restart_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         done_q    <= done_d;
      end
   end

   assign reg_address_out = addr_q;
   assign data_out        = data_q;
   assign done            = done_q;
   assign busy            = (state_q != StIdle);

endmodule

// File: tb/tb_denise_palette_loader.sv
// Self-checking bench for denise_palette_loader: directed scenarios plus a
// randomized phase, all compared against a behavioural palette-load model.
module tb_denise_palette_loader;

   logic        clk = 1'b0;
   logic        clk7_en = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  bus_address_in = 8'hFF;
   logic [15:0] bus_data_in = 16'h0000;
   logic        blank = 1'b0;
   logic        wr_en = 1'b0;
   logic [4:0]  wr_index = 5'd0;
   logic [11:0] wr_color = 12'h000;
   logic        start = 1'b0;
   logic [7:0]  reg_address_out;
   logic [15:0] data_out;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   denise_palette_loader dut (
      .clk             (clk),
      .clk7_en         (clk7_en),
      .reset           (reset),
      .bus_address_in  (bus_address_in),
      .bus_data_in     (bus_data_in),
      .blank           (blank),
      .wr_en           (wr_en),
      .wr_index        (wr_index),
      .wr_color        (wr_color),
      .start           (start),
      .reg_address_out (reg_address_out),
      .data_out        (data_out),
      .busy            (busy),
      .done            (done)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a run walks palette positions 0..31, consuming only
   // idle blanking slots; a completion tick follows, then an optional rerun.
   logic [11:0] sh_m [32];
   bit          m_load = 1'b0;
   bit          m_fin  = 1'b0;
   bit          m_rerun = 1'b0;
   int          m_pos  = 0;
   logic [7:0]  e_addr = 8'hFF;
   logic [15:0] e_data = 16'h0000;
   bit          e_busy = 1'b0;
   bit          e_done = 1'b0;
   bit          e_ins  = 1'b0;
   int          ins_cnt = 0;
   int          done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      if (reset) begin
         e_addr  = 8'hFF;
         e_data  = 16'h0000;
         e_done  = 1'b0;
         e_ins   = 1'b0;
         m_load  = 1'b0;
         m_fin   = 1'b0;
         m_rerun = 1'b0;
         m_pos   = 0;
      end else begin
         e_done = m_fin;
         e_ins  = m_load && blank && (bus_address_in == 8'hFF);
         if (e_ins) begin
            e_addr = 8'hC0 + 8'(m_pos);
            e_data = {4'h0, sh_m[m_pos]};
         end else begin
            e_addr = bus_address_in;
            e_data = bus_data_in;
         end
         if (start && (m_load || m_fin)) m_rerun = 1'b1;
         if (m_fin) begin
            m_fin   = 1'b0;
            m_load  = m_rerun;
            m_pos   = 0;
            m_rerun = 1'b0;
         end else if (m_load) begin
            if (e_ins) begin
               m_pos++;
               if (m_pos == 32) begin
                  m_load = 1'b0;
                  m_fin  = 1'b1;
               end
            end
         end else if (start) begin
            m_load = 1'b1;
            m_pos  = 0;
         end
      end
      if (wr_en) sh_m[wr_index] = wr_color;
      e_busy = m_load || m_fin;
   endtask

   // One clk7_en tick followed by a disabled clock edge (outputs must hold)
   task automatic step();
      model_edge();
      clk7_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clk7_en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("addr", 32'(reg_address_out), 32'(e_addr));
      chk("data", 32'(data_out), 32'(e_data));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      if (e_ins) ins_cnt++;
      if (e_done) done_cnt++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 200 && e_busy; t++) step();
      chk(tag, 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      step();
      step();
      chk("rst_addr", 32'(reg_address_out), 32'hFF);
      chk("rst_data", 32'(data_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      reset = 1'b0;

      // Full load on an idle bus
      blank = 1'b1;
      for (int i = 0; i < 32; i++) begin
         wr_en    = 1'b1;
         wr_index = 5'(i);
         wr_color = 12'h100 + 12'(i);
         step();
      end
      wr_en = 1'b0;
      pulse_start();
      for (int i = 0; i < 32; i++) begin
         step();
         chk("t1_addr", 32'(reg_address_out), 32'hC0 + 32'(i));
         chk("t1_data", 32'(data_out), 32'h0100 + 32'(i));
      end
      step();
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_busy", 32'(busy), 32'd0);
      step();
      chk("t1_done_clr", 32'(done), 32'd0);

      // Contention with alternating Agnus writes
      begin
         int k = 0;
         ins_cnt = 0;
         pulse_start();
         for (int t = 0; t < 200 && e_busy; t++) begin
            if (t % 2 == 0) begin
               bus_address_in = 8'hC0;
               bus_data_in    = 16'h0ABC;
            end else begin
               bus_address_in = 8'hFF;
               bus_data_in    = 16'($urandom);
            end
            step();
            if (t % 2 == 0) begin
               chk("t2_agnus_addr", 32'(reg_address_out), 32'hC0);
               chk("t2_agnus_data", 32'(data_out), 32'h0ABC);
            end else if (k < 32) begin
               chk("t2_order", 32'(reg_address_out), 32'hC0 + 32'(k));
               k++;
            end
         end
         bus_address_in = 8'hFF;
         chk("t2_inserted", 32'(ins_cnt), 32'd32);
         chk("t2_end", 32'(busy), 32'd0);
      end

      // Blanking pause after 10 entries
      pulse_start();
      for (int i = 0; i < 10; i++) step();
      blank = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t3_paused", 32'(reg_address_out), 32'hFF);
      end
      blank = 1'b1;
      step();
      chk("t3_resume_addr", 32'(reg_address_out), 32'hCA);
      chk("t3_resume_data", 32'(data_out), 32'h010A);
      drain("t3_end");

      // Two starts during a load collapse into one rerun
      ins_cnt  = 0;
      done_cnt = 0;
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      pulse_start();
      for (int i = 0; i < 3; i++) step();
      pulse_start();
      drain("t4_end");
      chk("t4_inserted", 32'(ins_cnt), 32'd64);
      chk("t4_dones", 32'(done_cnt), 32'd2);

      // Shadow writes racing the load; tick t issues entry t-1
      pulse_start();
      for (int t = 1; t <= 32; t++) begin
         wr_en    = (t == 5) || (t == 6) || (t == 11);
         wr_index = (t == 5) ? 5'd3 : (t == 6) ? 5'd20 : 5'd10;
         wr_color = (t == 5) ? 12'hA03 : (t == 6) ? 12'hA14 : 12'hA0A;
         step();
         if (t == 4) chk("t5_old3", 32'(data_out), 32'h0103);
         if (t == 11) chk("t5_same_tick", 32'(data_out), 32'h010A);
         if (t == 21) chk("t5_new20", 32'(data_out), 32'h0A14);
      end
      wr_en = 1'b0;
      drain("t5_end");
      pulse_start();
      for (int t = 1; t <= 32; t++) begin
         step();
         if (t == 4) chk("t5_next3", 32'(data_out), 32'h0A03);
         if (t == 11) chk("t5_next10", 32'(data_out), 32'h0A0A);
      end
      drain("t5_end2");

      // Reset mid-load at idx 15
      pulse_start();
      for (int i = 0; i < 15; i++) step();
      chk("t6_pre_addr", 32'(reg_address_out), 32'hCE);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_rst_addr", 32'(reg_address_out), 32'hFF);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      bus_address_in = 8'h55;
      bus_data_in    = 16'h1234;
      step();
      chk("t6_pass_addr", 32'(reg_address_out), 32'h55);
      chk("t6_pass_data", 32'(data_out), 32'h1234);
      chk("t6_no_done", 32'(done), 32'd0);
      bus_address_in = 8'hFF;
      step();
      chk("t6_idle_busy", 32'(busy), 32'd0);
      pulse_start();
      step();
      chk("t6_restart_addr", 32'(reg_address_out), 32'hC0);
      chk("t6_restart_data", 32'(data_out), 32'h0100);
      drain("t6_end");

      // Randomized traffic
      for (int t = 0; t < 400; t++) begin
         blank = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 0) bus_address_in = 8'hFF;
         else bus_address_in = 8'($urandom_range(0, 254));
         bus_data_in = 16'($urandom);
         wr_en       = ($urandom_range(0, 7) == 0);
         wr_index    = 5'($urandom);
         wr_color    = 12'($urandom);
         start       = ($urandom_range(0, 39) == 0);
         step();
      end
      start          = 1'b0;
      wr_en          = 1'b0;
      blank          = 1'b1;
      bus_address_in = 8'hFF;
      drain("t7_end");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation time limit");
   end

endmodule
